// File: rtl/peak_muldiv.sv
// RV32M multiply/divide sequencer: one-cycle registered multiplier plus a
// radix-2 restoring divider, with valid/ready request and result handshakes.
module peak_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [2:0]      REQ_OP,
    input  logic [XLEN-1:0] REQ_RS1,
    input  logic [XLEN-1:0] REQ_RS2,
    input  logic [4:0]      REQ_RD,
    input  logic            KILL,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic [XLEN-1:0] RES_DATA,
    output logic [4:0]      RES_RD,
    output logic            BUSY
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state;
    logic [1:0]      op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   cnt;
    logic            neg_quo;
    logic            neg_rem;
    logic [4:0]      rd;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_rd;

    logic            div_signed;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN:0]   mul_a;
    logic [XLEN:0]   mul_b;
    logic [2*XLEN+1:0] prod;
    logic [XLEN-1:0] mul_res;
    logic            unused_prod;

    assign REQ_READY = (state == S_IDLE);
    assign BUSY      = (state != S_IDLE);
    assign RES_VALID = (state == S_DONE);
    assign RES_DATA  = res_data;
    assign RES_RD    = res_rd;

    // Request decode: divide special cases and operand magnitudes for signed ops.
    always_comb begin
        div_signed = REQ_OP[2] & ~REQ_OP[0];
        div_zero   = (REQ_RS2 == '0);
        div_ovf    = div_signed && (REQ_RS1 == MOST_NEG) && (REQ_RS2 == '1);
        rs1_abs    = (div_signed && REQ_RS1[XLEN-1]) ? -REQ_RS1 : REQ_RS1;
        rs2_abs    = (div_signed && REQ_RS2[XLEN-1]) ? -REQ_RS2 : REQ_RS2;
    end

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        shifted = {rem, opa[XLEN-1]};
        diff    = shifted - {1'b0, opb};
        quo_fix = neg_quo ? -opa : opa;
        rem_fix = neg_rem ? -rem : rem;
    end

    // Operands are extended to XLEN+1 bits, then to the full product width so
    // that a plain multiply yields the correct two's-complement product.
    always_comb begin
        mul_a   = {(op != 2'b11) & opa[XLEN-1], opa};
        mul_b   = {(op == 2'b01) & opb[XLEN-1], opb};
        prod    = {{(XLEN+1){mul_a[XLEN]}}, mul_a} * {{(XLEN+1){mul_b[XLEN]}}, mul_b};
        mul_res = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            op       <= '0;
            opa      <= '0;
            opb      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            rd       <= '0;
            res_data <= '0;
            res_rd   <= '0;
        end else if (KILL) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        op      <= REQ_OP[1:0];
                        opa     <= rs1_abs;
                        opb     <= rs2_abs;
                        rd      <= REQ_RD;
                        rem     <= '0;
                        cnt     <= CW'(XLEN - 1);
                        neg_quo <= div_signed & (REQ_RS1[XLEN-1] ^ REQ_RS2[XLEN-1]);
                        neg_rem <= div_signed & REQ_RS1[XLEN-1];
                        if (!REQ_OP[2]) begin
                            state <= S_MUL;
                        end else if (div_zero) begin
                            res_data <= REQ_OP[1] ? REQ_RS1 : '1;
                            res_rd   <= REQ_RD;
                            state    <= S_DONE;
                        end else if (div_ovf) begin
                            res_data <= REQ_OP[1] ? '0 : MOST_NEG;
                            res_rd   <= REQ_RD;
                            state    <= S_DONE;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    res_data <= mul_res;
                    res_rd   <= rd;
                    state    <= S_DONE;
                end
                S_DIV: begin
                    // opa doubles as the dividend shifter and quotient collector.
                    if (diff[XLEN]) begin
                        rem <= shifted[XLEN-1:0];
                        opa <= {opa[XLEN-2:0], 1'b0};
                    end else begin
                        rem <= diff[XLEN-1:0];
                        opa <= {opa[XLEN-2:0], 1'b1};
                    end
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    res_data <= op[1] ? rem_fix : quo_fix;
                    res_rd   <= rd;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (RES_READY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peak_muldiv.sv
// Directed self-checking bench for peak_muldiv: multiply, divide, special
// divide cases, backpressure, kill and asynchronous reset.
module tb_peak_muldiv;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [2:0]  REQ_OP;
    logic [31:0] REQ_RS1;
    logic [31:0] REQ_RS2;
    logic [4:0]  REQ_RD;
    logic        KILL;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA;
    logic [4:0]  RES_RD;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    peak_muldiv #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_RD(REQ_RD),
        .KILL(KILL),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_RD(RES_RD), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Latency counts the accept edge as edge 1; viol counts cycles where
    // BUSY was low or REQ_READY high while waiting for the result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] data,
                          output logic [4:0] rdo, output int lat, output int viol);
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_RS1   = a;
        REQ_RS2   = b;
        REQ_RD    = rd;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        REQ_OP    = 3'($urandom);
        REQ_RS1   = $urandom;
        REQ_RS2   = $urandom;
        REQ_RD    = 5'($urandom);
        lat  = 1;
        viol = 0;
        if (BUSY !== 1'b1 || REQ_READY !== 1'b0) viol++;
        while (RES_VALID !== 1'b1 && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
            if (BUSY !== 1'b1 || REQ_READY !== 1'b0) viol++;
        end
        data = RES_DATA;
        rdo  = RES_RD;
    endtask

    task automatic release_result();
        @(negedge CLK);
        RES_READY = 1'b1;
        @(posedge CLK);
        #1;
        RES_READY = 1'b0;
    endtask

    task automatic check_vectors(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_data, input int exp_lat);
        logic [31:0] data;
        logic [4:0]  rdo;
        int          lat;
        int          viol;
        run_op(op, a, b, rd, data, rdo, lat, viol);
        total++;
        if (data !== exp_data) begin
            bad++;
            $display("[TB] FAIL %s data: got %h expected %h", name, data, exp_data);
        end
        total++;
        if (rdo !== rd) begin
            bad++;
            $display("[TB] FAIL %s rd: got %0d expected %0d", name, rdo, rd);
        end
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("[TB] FAIL %s busy/ready while pending: got %0d bad cycles expected 0", name, viol);
        end
        release_result();
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_OP    = 3'b000;
        REQ_RS1   = '0;
        REQ_RS2   = '0;
        REQ_RD    = '0;
        KILL      = 1'b0;
        RES_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || REQ_READY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset flags: got valid=%b busy=%b ready=%b expected 0 0 1",
                     RES_VALID, BUSY, REQ_READY);
        end
        total++;
        if (RES_DATA !== 32'h0 || RES_RD !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset result: got data=%h rd=%0d expected 0 0", RES_DATA, RES_RD);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_mul();
        check_vectors("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 2);
        check_vectors("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 2);
        check_vectors("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 2);
        check_vectors("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 2);
        check_vectors("mul_big", 3'b000, 32'h00012345, 32'h00010000, 5'd7, 32'h23450000, 2);
    endtask

    task automatic test_div();
        check_vectors("div",  3'b100, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 34);
        check_vectors("rem",  3'b110, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 34);
        check_vectors("divu", 3'b101, 32'd100,      32'd7, 5'd12, 32'd14,       34);
        check_vectors("remu", 3'b111, 32'd100,      32'd7, 5'd13, 32'd2,        34);
        check_vectors("div_negdiv", 3'b100, 32'd20, 32'hFFFFFFFA, 5'd14, 32'hFFFFFFFD, 34);
        check_vectors("rem_negdiv", 3'b110, 32'd20, 32'hFFFFFFFA, 5'd15, 32'd2,        34);
    endtask

    task automatic test_special();
        check_vectors("divu_zero", 3'b101, 32'h00001234, 32'd0, 5'd16, 32'hFFFFFFFF, 1);
        check_vectors("remu_zero", 3'b111, 32'h00001234, 32'd0, 5'd17, 32'h00001234, 1);
        check_vectors("rem_zero",  3'b110, 32'hFFFFFFFB, 32'd0, 5'd18, 32'hFFFFFFFB, 1);
        check_vectors("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1);
        check_vectors("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        logic [4:0]  rdo;
        int          lat;
        int          viol;
        int          unstable;
        run_op(3'b000, 32'd9, 32'd11, 5'd21, data, rdo, lat, viol);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            if (RES_VALID !== 1'b1 || REQ_READY !== 1'b0 || RES_DATA !== 32'd99 || RES_RD !== 5'd21)
                unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("[TB] FAIL backpressure hold: got %0d unstable cycles expected 0", unstable);
        end
        @(negedge CLK);
        RES_READY = 1'b1;
        REQ_VALID = 1'b1;
        REQ_OP    = 3'b000;
        REQ_RS1   = 32'd5;
        REQ_RS2   = 32'd6;
        REQ_RD    = 5'd22;
        @(posedge CLK);
        #1;
        RES_READY = 1'b0;
        total++;
        if (RES_VALID !== 1'b0 || REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL release to idle: got valid=%b ready=%b busy=%b expected 0 1 0",
                     RES_VALID, REQ_READY, BUSY);
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        total++;
        if (BUSY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL back-to-back accept: got busy=%b expected 1", BUSY);
        end
        @(posedge CLK);
        #1;
        total++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 32'd30 || RES_RD !== 5'd22) begin
            bad++;
            $display("[TB] FAIL back-to-back result: got valid=%b data=%h rd=%0d expected 1 0000001e 22",
                     RES_VALID, RES_DATA, RES_RD);
        end
        release_result();
    endtask

    task automatic test_kill();
        int seen_valid;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP    = 3'b101;
        REQ_RS1   = 32'd1000;
        REQ_RS2   = 32'd3;
        REQ_RD    = 5'd23;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        seen_valid = 0;
        repeat (9) begin
            @(posedge CLK);
            #1;
            if (RES_VALID === 1'b1) seen_valid++;
        end
        @(negedge CLK);
        KILL = 1'b1;
        @(posedge CLK);
        #1;
        KILL = 1'b0;
        total++;
        if (BUSY !== 1'b0 || REQ_READY !== 1'b1 || RES_VALID !== 1'b0) begin
            bad++;
            $display("[TB] FAIL kill mid-divide: got busy=%b ready=%b valid=%b expected 0 1 0",
                     BUSY, REQ_READY, RES_VALID);
        end
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (RES_VALID === 1'b1 || BUSY === 1'b1) seen_valid++;
        end
        total++;
        if (seen_valid != 0) begin
            bad++;
            $display("[TB] FAIL killed divide result: got %0d active cycles expected 0", seen_valid);
        end
        @(negedge CLK);
        KILL      = 1'b1;
        REQ_VALID = 1'b1;
        REQ_OP    = 3'b000;
        @(posedge CLK);
        #1;
        KILL      = 1'b0;
        REQ_VALID = 1'b0;
        total++;
        if (BUSY !== 1'b0 || REQ_READY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL kill with request: got busy=%b ready=%b expected 0 1", BUSY, REQ_READY);
        end
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP    = 3'b000;
        REQ_RS1   = 32'd2;
        REQ_RS2   = 32'd3;
        REQ_RD    = 5'd24;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        KILL      = 1'b1;
        RES_READY = 1'b1;
        @(posedge CLK);
        #1;
        KILL      = 1'b0;
        RES_READY = 1'b0;
        total++;
        if (RES_VALID !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL kill in done: got valid=%b busy=%b expected 0 0", RES_VALID, BUSY);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP    = 3'b100;
        REQ_RS1   = 32'd12345;
        REQ_RS2   = 32'd17;
        REQ_RD    = 5'd25;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        total++;
        if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || REQ_READY !== 1'b1 ||
            RES_DATA !== 32'h0 || RES_RD !== 5'd0) begin
            bad++;
            $display("[TB] FAIL async reset: got valid=%b busy=%b ready=%b data=%h rd=%0d expected 0 0 1 0 0",
                     RES_VALID, BUSY, REQ_READY, RES_DATA, RES_RD);
        end
        @(negedge CLK);
        RST = 1'b0;
        check_vectors("mul_after_reset", 3'b000, 32'd6, 32'd7, 5'd9, 32'd42, 2);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
